// File: rtl/proc_pkg.sv
// Shared definitions for the unified memory arbiter slice.
// Holds the transaction-sequencer state encoding and the owner encoding
// used by the arbiter top and its winner-select sub-module.
package proc_pkg;

    // Transaction sequencer states
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] RESP = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    // Owner of the transaction in flight
    localparam logic OWN_I = 1'b0;
    localparam logic OWN_D = 1'b1;

    // Width of a counter that must hold values 0..limit inclusive
    function automatic int cnt_width(input int limit);
        return (limit < 1) ? 1 : $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/unified_mem_arbiter_pick.sv
// mem_arb_pick: winner select and starvation counter.
// Data has fixed priority over fetch, except when fetch has been passed over
// STARVE_LIMIT times in a row while requesting; then fetch is forced to win.
// Ports:
//   clk, rst  - clock, asynchronous active-low reset
//   i_req     - fetch request
//   d_req     - data request
//   grant     - strobe: a transaction is being granted this cycle
//   winner    - OWN_I / OWN_D, valid whenever at least one request is high
module mem_arb_pick
    import proc_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_req,
    input  logic d_req,
    input  logic grant,
    output logic winner
);

    localparam int CNT_W = cnt_width(STARVE_LIMIT);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0] starve_cnt_q;
    logic [CNT_W-1:0] starve_cnt_d;
    logic             starved_s;

    assign starved_s = (starve_cnt_q == LIMIT);

    // Winner select: data first unless fetch is both pending and starved
    always_comb begin
        if (d_req && !(i_req && starved_s)) begin
            winner = OWN_D;
        end else begin
            winner = OWN_I;
        end
    end

    // Starvation counter next state: only data grants over a waiting fetch count
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (grant) begin
            if (winner == OWN_I) begin
                starve_cnt_d = '0;
            end else if (i_req && !starved_s) begin
                starve_cnt_d = starve_cnt_q + CNT_W'(1);
            end else begin
                starve_cnt_d = starve_cnt_q;
            end
        end else begin
            starve_cnt_d = starve_cnt_q;
        end
    end

    // Starvation counter register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            starve_cnt_q <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end

endmodule

// File: rtl/unified_mem_arbiter.sv
// unified_mem_arbiter: shares one single-ported memory between the core's
// instruction-fetch port (read-only) and data port (load/store).
// One transaction at a time: IDLE -> REQ -> RESP -> DONE -> IDLE.
// Ports:
//   clk, rst                 - clock, asynchronous active-low reset
//   i_req/i_addr             - fetch request (held until i_done)
//   i_done/i_rdata           - fetch completion pulse and held read data
//   d_req/d_we/d_addr/d_wdata/d_be - data request (held until d_done)
//   d_done/d_rdata           - data completion pulse and held load data
//   mem_req/mem_we/mem_addr/mem_wdata/mem_be - memory request side
//   mem_ready                - memory accepts the request
//   mem_rvalid/mem_rdata     - memory response
module unified_mem_arbiter
    import proc_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_req,
    input  logic [ADDR_W-1:0]   i_addr,
    output logic                i_done,
    output logic [DATA_W-1:0]   i_rdata,
    input  logic                d_req,
    input  logic                d_we,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    input  logic [DATA_W/8-1:0] d_be,
    output logic                d_done,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_be,
    input  logic                mem_ready,
    input  logic                mem_rvalid,
    input  logic [DATA_W-1:0]   mem_rdata
);

    localparam int BE_W = DATA_W / 8;

    logic [1:0]        state_q,   state_d;
    logic              owner_q,   owner_d;
    logic [ADDR_W-1:0] addr_q,    addr_d;
    logic              we_q,      we_d;
    logic [DATA_W-1:0] wdata_q,   wdata_d;
    logic [BE_W-1:0]   be_q,      be_d;
    logic              mem_req_q, mem_req_d;
    logic              i_done_q,  i_done_d;
    logic              d_done_q,  d_done_d;
    logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;

    logic grant_s;
    logic winner_s;

    // Requester inputs only matter while idle
    assign grant_s = (state_q == IDLE) && (i_req || d_req);

    mem_arb_pick #(
        .STARVE_LIMIT(STARVE_LIMIT)
    ) u_pick (
        .clk    (clk),
        .rst    (rst),
        .i_req  (i_req),
        .d_req  (d_req),
        .grant  (grant_s),
        .winner (winner_s)
    );

    // Sequencer next state, request latching and response capture
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        addr_d    = addr_q;
        we_d      = we_q;
        wdata_d   = wdata_q;
        be_d      = be_q;
        i_rdata_d = i_rdata_q;
        d_rdata_d = d_rdata_q;
        case (state_q)
            IDLE: begin
                if (grant_s) begin
                    state_d = REQ;
                    owner_d = winner_s;
                    if (winner_s == OWN_D) begin
                        addr_d  = d_addr;
                        we_d    = d_we;
                        wdata_d = d_wdata;
                        be_d    = d_be;
                    end else begin
                        addr_d  = i_addr;
                        we_d    = 1'b0;
                        wdata_d = '0;
                        be_d    = '1;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            REQ: begin
                if (mem_ready) begin
                    state_d = RESP;
                end else begin
                    state_d = REQ;
                end
            end
            RESP: begin
                if (mem_rvalid) begin
                    state_d = DONE;
                    // Store acks carry no data; d_rdata keeps the last load
                    if (owner_q == OWN_I) begin
                        i_rdata_d = mem_rdata;
                    end else if (!we_q) begin
                        d_rdata_d = mem_rdata;
                    end else begin
                        d_rdata_d = d_rdata_q;
                    end
                end else begin
                    state_d = RESP;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // Outputs are registered, so decode them from the next state
        mem_req_d = (state_d == REQ);
        i_done_d  = (state_d == DONE) && (owner_q == OWN_I);
        d_done_d  = (state_d == DONE) && (owner_q == OWN_D);
    end

    // State, latched request and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            owner_q   <= OWN_I;
            addr_q    <= '0;
            we_q      <= 1'b0;
            wdata_q   <= '0;
            be_q      <= '0;
            mem_req_q <= 1'b0;
            i_done_q  <= 1'b0;
            d_done_q  <= 1'b0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            addr_q    <= addr_d;
            we_q      <= we_d;
            wdata_q   <= wdata_d;
            be_q      <= be_d;
            mem_req_q <= mem_req_d;
            i_done_q  <= i_done_d;
            d_done_q  <= d_done_d;
            i_rdata_q <= i_rdata_d;
            d_rdata_q <= d_rdata_d;
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_be    = be_q;
    assign i_done    = i_done_q;
    assign i_rdata   = i_rdata_q;
    assign d_done    = d_done_q;
    assign d_rdata   = d_rdata_q;

endmodule
